// File: rtl/combo_lock_n_if.sv
// Keypad-side bundle of the combination lock: digit entry strobes in, 7-segment and status out.
// master drives the keypad inputs; slave is the lock itself.
interface combo_lock_n_if;
  logic       enter;
  logic       prog;
  logic [3:0] digit;
  logic [6:0] hex0;
  logic [6:0] hex1;
  logic [6:0] hex2;
  logic [6:0] hex3;
  logic [6:0] hex4;
  logic [6:0] hex5;
  logic       is_open;
  logic       is_closed;

  modport master (
    output enter, prog, digit,
    input  hex0, hex1, hex2, hex3, hex4, hex5, is_open, is_closed
  );

  modport slave (
    input  enter, prog, digit,
    output hex0, hex1, hex2, hex3, hex4, hex5, is_open, is_closed
  );
endinterface

// File: rtl/combo_lock_n.sv
// Combination lock: BCD code entry, reprogramming and 7-segment status; COMBO_LOCKOUT_EN adds a timed lockout.
// Latency: state updates on the clk edge that samples a strobe; displays are combinational from state and live digit.
// Backpressure: none; every enter-high cycle is one entry, strobes a state cannot use are dropped.
module combo_lock_n #(
  parameter int                      NUM_DIGITS     = 6,
  parameter logic [4*NUM_DIGITS-1:0] DEFAULT_CODE   = 24'h722297,
  parameter int                      MAX_FAILS      = 3,
  parameter int                      LOCKOUT_CYCLES = 1000
) (
  input logic           clk,
  input logic           reset,
  combo_lock_n_if.slave bus
);

  localparam int            IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NUM_DIGITS - 1);

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [6:0] SEG_P   = 7'h0C;
  localparam logic [6:0] SEG_E   = 7'h06;
  localparam logic [6:0] SEG_R   = 7'h2F;
  localparam logic [6:0] SEG_O   = 7'h40;
  localparam logic [6:0] SEG_N   = 7'h2B;
  localparam logic [6:0] SEG_C   = 7'h46;
  localparam logic [6:0] SEG_L   = 7'h47;
  localparam logic [6:0] SEG_S   = 7'h12;
  localparam logic [6:0] SEG_D   = 7'h21;

  if (NUM_DIGITS < 1 || NUM_DIGITS > 8 || MAX_FAILS < 1 || MAX_FAILS > 15 || LOCKOUT_CYCLES < 1) begin : g_cfg_check
    $error("combo_lock_n: parameter out of legal range");
  end

`ifdef COMBO_LOCKOUT_EN
  typedef enum logic [2:0] {ST_ENTRY, ST_OPEN, ST_CLOSED, ST_PROG, ST_LOCKOUT} state_t;
  localparam int            CW        = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCKOUT_CYCLES - 1);
  logic [CW-1:0] lock_cnt, lock_cnt_nxt;
  logic          lock_hit;
`else
  typedef enum logic [1:0] {ST_ENTRY, ST_OPEN, ST_CLOSED, ST_PROG} state_t;
`endif

  state_t                     state, state_nxt;
  logic [IW-1:0]              idx, idx_nxt;
  logic                       match, match_nxt;
  logic [3:0]                 fails, fails_nxt, fails_inc;
  logic [NUM_DIGITS-1:0][3:0] code, code_nxt;
  logic [IW-1:0]              nib_sel;
  logic                       digit_ok, valid, hit;

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    return 7'h40;
      4'd1:    return 7'h79;
      4'd2:    return 7'h24;
      4'd3:    return 7'h30;
      4'd4:    return 7'h19;
      4'd5:    return 7'h12;
      4'd6:    return 7'h02;
      4'd7:    return 7'h78;
      4'd8:    return 7'h00;
      4'd9:    return 7'h10;
      default: return SEG_OFF;
    endcase
  endfunction

  // idx 0 is the first-entered digit, held in the most significant nibble
  assign nib_sel   = LAST - idx;
  assign digit_ok  = (bus.digit <= 4'd9);
  assign valid     = bus.enter & digit_ok;
  assign hit       = (bus.digit == code[nib_sel]);
  assign fails_inc = (fails == 4'hF) ? fails : fails + 4'd1;
`ifdef COMBO_LOCKOUT_EN
  assign lock_hit  = ({1'b0, fails} + 5'd1) >= 5'(MAX_FAILS);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_ENTRY;
      idx      <= '0;
      match    <= 1'b1;
      fails    <= '0;
      code     <= DEFAULT_CODE;
`ifdef COMBO_LOCKOUT_EN
      lock_cnt <= '0;
`endif
    end else begin
      state    <= state_nxt;
      idx      <= idx_nxt;
      match    <= match_nxt;
      fails    <= fails_nxt;
      code     <= code_nxt;
`ifdef COMBO_LOCKOUT_EN
      lock_cnt <= lock_cnt_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt    = state;
    idx_nxt      = idx;
    match_nxt    = match;
    fails_nxt    = fails;
    code_nxt     = code;
`ifdef COMBO_LOCKOUT_EN
    lock_cnt_nxt = lock_cnt;
`endif
    case (state)
      ST_ENTRY: begin
        if (valid) begin
          match_nxt = match & hit;
          if (idx == LAST) begin
            idx_nxt = '0;
            if (match & hit) begin
              state_nxt = ST_OPEN;
              fails_nxt = '0;
            end else begin
              fails_nxt = fails_inc;
`ifdef COMBO_LOCKOUT_EN
              if (lock_hit) begin
                state_nxt    = ST_LOCKOUT;
                lock_cnt_nxt = '0;
              end else begin
                state_nxt = ST_CLOSED;
              end
`else
              state_nxt = ST_CLOSED;
`endif
            end
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      ST_OPEN: begin
        if (bus.prog) begin
          state_nxt = ST_PROG;
          idx_nxt   = '0;
        end
      end
      ST_PROG: begin
        if (valid) begin
          code_nxt[nib_sel] = bus.digit;
          if (idx == LAST) begin
            state_nxt = ST_ENTRY;
            idx_nxt   = '0;
            match_nxt = 1'b1;
          end else begin
            idx_nxt = idx + 1'b1;
          end
        end
      end
      ST_CLOSED: begin
        if (valid) begin
          state_nxt = ST_ENTRY;
          idx_nxt   = '0;
          match_nxt = 1'b1;
        end
      end
`ifdef COMBO_LOCKOUT_EN
      ST_LOCKOUT: begin
        if (lock_cnt == LOCK_LAST) begin
          state_nxt    = ST_ENTRY;
          lock_cnt_nxt = '0;
          fails_nxt    = '0;
          idx_nxt      = '0;
          match_nxt    = 1'b1;
        end else begin
          lock_cnt_nxt = lock_cnt + 1'b1;
        end
      end
`endif
      default: state_nxt = ST_ENTRY;
    endcase
  end

  always_comb begin
    bus.hex0      = SEG_OFF;
    bus.hex1      = SEG_OFF;
    bus.hex2      = SEG_OFF;
    bus.hex3      = SEG_OFF;
    bus.hex4      = SEG_OFF;
    bus.hex5      = SEG_OFF;
    bus.is_open   = 1'b0;
    bus.is_closed = 1'b0;
    if (!reset) begin
      bus.hex0 = seg_digit(bus.digit);
    end else begin
      case (state)
        ST_ENTRY, ST_PROG: begin
          if (state == ST_PROG) bus.hex5 = SEG_P;
          if (digit_ok) begin
            bus.hex0 = seg_digit(bus.digit);
          end else begin
            bus.hex4 = SEG_E;
            bus.hex3 = SEG_R;
            bus.hex2 = SEG_R;
            bus.hex1 = SEG_O;
            bus.hex0 = SEG_R;
          end
        end
        ST_OPEN: begin
          bus.hex3    = SEG_O;
          bus.hex2    = SEG_P;
          bus.hex1    = SEG_E;
          bus.hex0    = SEG_N;
          bus.is_open = 1'b1;
        end
        ST_CLOSED: begin
          bus.hex5      = SEG_C;
          bus.hex4      = SEG_L;
          bus.hex3      = SEG_O;
          bus.hex2      = SEG_S;
          bus.hex1      = SEG_E;
          bus.hex0      = SEG_D;
          bus.is_closed = 1'b1;
        end
`ifdef COMBO_LOCKOUT_EN
        ST_LOCKOUT: begin
          bus.hex5      = SEG_L;
          bus.hex4      = SEG_O;
          bus.hex3      = SEG_C;
          bus.is_closed = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_combo_lock_n.sv
// Bench for combo_lock_n: directed key sequences against a queue-based model of the lock,
// checked every cycle on the falling edge, plus literal glyph checks.
module tb_combo_lock_n;
  localparam int ND = 6;
  localparam int MF = 3;
  localparam int LC = 20;
  localparam int M_ENTRY = 0, M_OPEN = 1, M_CLOSED = 2, M_PROG = 3, M_LOCK = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  bit   chk_on = 1'b0;
  int   total = 0;
  int   bad   = 0;

  combo_lock_n_if bus();

  combo_lock_n #(
    .NUM_DIGITS    (ND),
    .DEFAULT_CODE  (24'h722297),
    .MAX_FAILS     (MF),
    .LOCKOUT_CYCLES(LC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // model: mode, entered digits so far, code as a digit list
  int m_mode, m_fails, m_lock;
  bit m_rst;
  int m_code[ND];
  int m_att[$];
  int m_new[$];

  task automatic model_reset();
    m_rst   = 1'b1;
    m_mode  = M_ENTRY;
    m_fails = 0;
    m_lock  = 0;
    m_att.delete();
    m_new.delete();
    m_code  = '{7, 2, 2, 2, 9, 7};
  endtask

  task automatic model_fail();
    if (m_fails < 15) m_fails++;
`ifdef COMBO_LOCKOUT_EN
    if (m_fails >= MF) begin
      m_mode = M_LOCK;
      m_lock = LC;
    end else begin
      m_mode = M_CLOSED;
    end
`else
    m_mode = M_CLOSED;
`endif
  endtask

  task automatic model_edge(input bit en, input bit pg, input int d);
    bit ok;
    bit valid;
    if (m_rst) return;
    valid = en && (d <= 9);
    case (m_mode)
      M_LOCK: begin
        m_lock--;
        if (m_lock == 0) begin
          m_mode  = M_ENTRY;
          m_fails = 0;
        end
      end
      M_OPEN: if (pg) begin
        m_mode = M_PROG;
        m_new.delete();
      end
      M_ENTRY: if (valid) begin
        m_att.push_back(d);
        if (m_att.size() == ND) begin
          ok = 1'b1;
          for (int i = 0; i < ND; i++) if (m_att[i] != m_code[i]) ok = 1'b0;
          m_att.delete();
          if (ok) begin
            m_mode  = M_OPEN;
            m_fails = 0;
          end else begin
            model_fail();
          end
        end
      end
      M_PROG: if (valid) begin
        m_new.push_back(d);
        if (m_new.size() == ND) begin
          for (int i = 0; i < ND; i++) m_code[i] = m_new[i];
          m_new.delete();
          m_att.delete();
          m_mode = M_ENTRY;
        end
      end
      M_CLOSED: if (valid) begin
        m_att.delete();
        m_mode = M_ENTRY;
      end
      default: ;
    endcase
  endtask

  function automatic logic [6:0] seg_of(input logic [7:0] c);
    case (c)
      "0": return 7'h40;  "1": return 7'h79;  "2": return 7'h24;  "3": return 7'h30;
      "4": return 7'h19;  "5": return 7'h12;  "6": return 7'h02;  "7": return 7'h78;
      "8": return 7'h00;  "9": return 7'h10;  "E": return 7'h06;  "r": return 7'h2F;
      "O": return 7'h40;  "P": return 7'h0C;  "n": return 7'h2B;  "C": return 7'h46;
      "L": return 7'h47;  "S": return 7'h12;  "d": return 7'h21;
      default: return 7'h7F;
    endcase
  endfunction

  // expected {hex5..hex0, is_open, is_closed} from the model and the live digit
  function automatic logic [43:0] model_out();
    logic [47:0] txt;
    logic [41:0] segs;
    logic [7:0]  dc;
    logic [7:0]  p;
    int d;
    d   = int'(bus.digit);
    dc  = (d <= 9) ? 8'(48 + d) : " ";
    p   = (m_mode == M_PROG) ? "P" : " ";
    txt = "      ";
    if (m_rst) txt = {"     ", dc};
    else case (m_mode)
      M_ENTRY, M_PROG: txt = (d <= 9) ? {p, "    ", dc} : {p, "ErrOr"};
      M_OPEN:          txt = "  OPEn";
      M_CLOSED:        txt = "CLOSEd";
      M_LOCK:          txt = "LOC   ";
      default:         txt = "      ";
    endcase
    for (int i = 0; i < 6; i++) segs[7*i +: 7] = seg_of(txt[8*i +: 8]);
    return {segs, !m_rst && (m_mode == M_OPEN), !m_rst && (m_mode == M_CLOSED || m_mode == M_LOCK)};
  endfunction

  task automatic chk(input string name, input logic [43:0] got, input logic [43:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s at %0t: got=%h want=%h", name, $time, got, want);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("cycle_outputs",
          {bus.hex5, bus.hex4, bus.hex3, bus.hex2, bus.hex1, bus.hex0, bus.is_open, bus.is_closed},
          model_out());
      chk("cycle_fails", 44'(dut.fails), 44'(m_fails));
    end
  end

  task automatic step(input bit en, input bit pg, input logic [3:0] d);
    bus.enter = en;
    bus.prog  = pg;
    bus.digit = d;
    @(posedge clk);
    model_edge(en, pg, int'(d));
    #2;
  endtask

  task automatic enter_code(input logic [23:0] c);
    for (int i = 5; i >= 0; i--) step(1'b1, 1'b0, c[4*i +: 4]);
  endtask

  task automatic do_reset();
    bus.enter = 1'b0;
    bus.prog  = 1'b0;
    reset     = 1'b0;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
    m_rst = 1'b0;
  endtask

  initial begin
    bus.enter = 1'b0;
    bus.prog  = 1'b0;
    bus.digit = 4'd5;
    model_reset();
    chk_on = 1'b1;
    #2;
    chk("reset_hex", 44'({bus.hex5, bus.hex4, bus.hex3, bus.hex2, bus.hex1, bus.hex0}),
        44'({{5{7'h7F}}, 7'h12}));
    chk("reset_status", 44'({bus.is_open, bus.is_closed}), 44'd0);
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
    m_rst = 1'b0;

    // correct default code opens
    enter_code(24'h722297);
    chk("open_text", 44'({bus.hex3, bus.hex2, bus.hex1, bus.hex0}), 44'({7'h40, 7'h0C, 7'h06, 7'h2B}));
    chk("open_flag", 44'(bus.is_open), 44'd1);
    chk("open_fails", 44'(dut.fails), 44'd0);
    step(1'b1, 1'b0, 4'd7);
    chk("open_ignores_enter", 44'(bus.is_open), 44'd1);

    // wrong code closes; next enter returns to entry
    do_reset();
    enter_code(24'h022297);
    chk("closed_text", 44'({bus.hex5, bus.hex4, bus.hex3, bus.hex2, bus.hex1, bus.hex0}),
        44'({7'h46, 7'h47, 7'h40, 7'h12, 7'h06, 7'h21}));
    chk("closed_flag", 44'(bus.is_closed), 44'd1);
    step(1'b1, 1'b0, 4'd4);
    chk("reentry_hex0", 44'({bus.hex0, bus.is_closed}), 44'({7'h19, 1'b0}));

    // invalid digits are ignored and show ErrOr
    step(1'b1, 1'b0, 4'd12);
    step(1'b1, 1'b0, 4'd12);
    step(1'b1, 1'b0, 4'd15);
    chk("error_text", 44'({bus.hex5, bus.hex4, bus.hex3, bus.hex2, bus.hex1, bus.hex0}),
        44'({7'h7F, 7'h06, 7'h2F, 7'h2F, 7'h40, 7'h2F}));
    enter_code(24'h722297);
    chk("open_after_invalid", 44'(bus.is_open), 44'd1);

    // reprogram with prog and enter together
    step(1'b1, 1'b1, 4'd3);
    chk("prog_p", 44'({bus.hex5, bus.hex0}), 44'({7'h0C, 7'h30}));
    enter_code(24'h123456);
    chk("prog_done", 44'({bus.hex5, bus.is_open}), 44'({7'h7F, 1'b0}));
    enter_code(24'h722297);
    chk("old_code_closed", 44'(bus.is_closed), 44'd1);
    step(1'b1, 1'b0, 4'd0);
    enter_code(24'h123456);
    chk("new_code_open", 44'(bus.is_open), 44'd1);

    // reset during programming discards the partial code
    step(1'b0, 1'b1, 4'd0);
    step(1'b1, 1'b0, 4'd9);
    step(1'b1, 1'b0, 4'd8);
    step(1'b1, 1'b0, 4'd7);
    do_reset();
    step(1'b0, 1'b1, 4'd5);
    enter_code(24'h722297);
    chk("default_after_reset", 44'(bus.is_open), 44'd1);

`ifdef COMBO_LOCKOUT_EN
    do_reset();
    for (int k = 0; k < 3; k++) begin
      enter_code(24'h000000);
      if (k < 2) step(1'b1, 1'b0, 4'd1);
    end
    chk("lock_text", 44'({bus.hex5, bus.hex4, bus.hex3, bus.hex2, bus.hex1, bus.hex0, bus.is_closed}),
        44'({7'h47, 7'h40, 7'h46, {3{7'h7F}}, 1'b1}));
    for (int k = 0; k < LC - 1; k++) step(1'b1, 1'b1, 4'd7);
    chk("lock_held", 44'(bus.is_closed), 44'd1);
    step(1'b1, 1'b0, 4'd7);
    chk("lock_released", 44'({bus.is_closed, bus.hex0}), 44'({1'b0, 7'h78}));
    enter_code(24'h722297);
    chk("open_after_lock", 44'(bus.is_open), 44'd1);
`else
    do_reset();
    for (int k = 0; k < 16; k++) begin
      enter_code(24'h000000);
      step(1'b1, 1'b0, 4'd1);
    end
    chk("fails_saturate", 44'(dut.fails), 44'd15);
    enter_code(24'h722297);
    chk("open_clears_fails", 44'({bus.is_open, dut.fails}), 44'({1'b1, 4'd0}));
`endif

    step(1'b0, 1'b0, 4'd0);
    @(posedge clk);
    #2;
    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
